sirv_gnrl_pipe_lrs: RTL and testbench

- Parametrised elastic pipeline of DEPTH register stages with a valid/ready handshake on each side.
- Every data register has a load enable and reloads the runtime reset value rst_v on asynchronous reset.
- Optional per-stage skid entry (CUT_READY) breaks the combinational ready path.
- Synchronous flush and an occupancy count are provided.
- Used between core pipeline units and bus/AGU paths that need timing cuts with known post-reset data.

---
 rtl/sirv_gnrl_pipe_lrs_stage.sv | 97 +++++++++
 rtl/sirv_gnrl_pipe_lrs.sv | 77 +++++++
 tb/tb_sirv_gnrl_pipe_lrs.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sirv_gnrl_pipe_lrs_stage.sv
// One elastic pipeline stage: a main entry plus, when CUT_READY=1, a skid entry
// that lets the upstream ready come straight from a flop.
module sirv_gnrl_pipe_lrs_stage #(
   parameter int DW        = 32,
   parameter int CUT_READY = 0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [DW-1:0] rst_v_i,
   input  logic          flush_i,
   input  logic          in_vld_i,
   output logic          in_rdy_o,
   input  logic [DW-1:0] in_dat_i,
   output logic          out_vld_o,
   input  logic          out_rdy_i,
   output logic [DW-1:0] out_dat_o
);

   logic          m_vld_q, m_vld_d;
   logic          s_vld_q, s_vld_d;
   logic [DW-1:0] m_dat_q, m_dat_d;
   logic [DW-1:0] s_dat_q;
   logic          m_ld, s_ld, m_from_s;
   logic          in_fire, out_fire;

   assign in_rdy_o  = (CUT_READY != 0) ? ~s_vld_q : (~m_vld_q | out_rdy_i);
   assign in_fire   = in_vld_i & in_rdy_o;
   assign out_fire  = m_vld_q & out_rdy_i;
   assign out_vld_o = m_vld_q;
   assign out_dat_o = m_dat_q;
   assign m_dat_d   = m_from_s ? s_dat_q : in_dat_i;

   // Flush only drops valid bits; data registers keep their contents.
   always_comb begin
      m_vld_d  = m_vld_q;
      s_vld_d  = s_vld_q;
      m_ld     = 1'b0;
      s_ld     = 1'b0;
      m_from_s = 1'b0;
      if (flush_i) begin
         m_vld_d = 1'b0;
         s_vld_d = 1'b0;
      end else if (CUT_READY == 0) begin
         if (in_fire) begin
            m_vld_d = 1'b1;
            m_ld    = 1'b1;
         end else if (out_fire) begin
            m_vld_d = 1'b0;
         end
      end else if (out_fire) begin
         if (s_vld_q) begin
            m_ld     = 1'b1;
            m_from_s = 1'b1;
            s_vld_d  = 1'b0;
         end else if (in_fire) begin
            m_ld = 1'b1;
         end else begin
            m_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         if (!m_vld_q) begin
            m_vld_d = 1'b1;
            m_ld    = 1'b1;
         end else begin
            s_vld_d = 1'b1;
            s_ld    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_vld_q <= 1'b0;
         s_vld_q <= 1'b0;
      end else begin
         m_vld_q <= m_vld_d;
         s_vld_q <= s_vld_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_dat_q <= rst_v_i;
      end else if (m_ld) begin
         m_dat_q <= m_dat_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_dat_q <= rst_v_i;
      end else if (s_ld) begin
         s_dat_q <= in_dat_i;
      end
   end

endmodule

// File: rtl/sirv_gnrl_pipe_lrs.sv
// Elastic pipeline of DEPTH stages with runtime reset value, flush and occupancy.
// Stage k's output side feeds stage k+1's input side.
module sirv_gnrl_pipe_lrs #(
   parameter  int DW        = 32,
   parameter  int DEPTH     = 2,
   parameter  int CUT_READY = 0,
   localparam int MAXOCC    = DEPTH * (1 + CUT_READY),
   localparam int CW        = $clog2(MAXOCC + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] rst_v,
   input  logic          flush,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [CW-1:0] occ
);

   logic [DEPTH:0] vld_c;
   logic [DEPTH:0] rdy_c;
   logic [DW-1:0]  dat_c [DEPTH+1];
   logic [CW-1:0]  occ_q, occ_d;
   logic           in_fire, out_fire;

   assign vld_c[0]     = i_vld;
   assign dat_c[0]     = i_dat;
   assign rdy_c[DEPTH] = o_rdy;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      sirv_gnrl_pipe_lrs_stage #(
         .DW        (DW),
         .CUT_READY (CUT_READY)
      ) u_stage (
         .clk_i     (clk),
         .rst_ni    (rst_n),
         .rst_v_i   (rst_v),
         .flush_i   (flush),
         .in_vld_i  (vld_c[k]),
         .in_rdy_o  (rdy_c[k]),
         .in_dat_i  (dat_c[k]),
         .out_vld_o (vld_c[k+1]),
         .out_rdy_i (rdy_c[k+1]),
         .out_dat_o (dat_c[k+1])
      );
   end

   // Input is refused while in reset or flushing, regardless of stage state.
   assign i_rdy    = rst_n & ~flush & rdy_c[0];
   assign o_vld    = vld_c[DEPTH];
   assign o_dat    = dat_c[DEPTH];
   assign in_fire  = i_vld & i_rdy;
   assign out_fire = o_vld & o_rdy;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else begin
         occ_d = occ_q + CW'(in_fire) - CW'(out_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;

endmodule

// File: tb/tb_sirv_gnrl_pipe_lrs.sv
// Bench for sirv_gnrl_pipe_lrs: three configurations checked against a queue model
// where the oldest item is visible once it has aged DEPTH edges.
module tb_sirv_gnrl_pipe_lrs;

   localparam int DEP  [3] = '{2, 2, 1};
   localparam int CRV  [3] = '{0, 1, 0};
   localparam int MAXO [3] = '{2, 4, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rst_v;
   logic        flush  [3];
   logic        i_vld  [3];
   logic        o_rdy  [3];
   logic [31:0] i_dat  [3];
   logic        i_rdy_w[3];
   logic        o_vld_w[3];
   logic [31:0] o_dat_w[3];
   logic [1:0]  occ0;
   logic [2:0]  occ1;
   logic [0:0]  occ2;
   logic [31:0] occ_v  [3];

   logic [31:0] mq [3][$];
   int          ma [3][$];
   logic        fin [3];
   logic        fout[3];
   logic [31:0] fdat[3];
   int          nxt [3];
   int          pops[3];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   sirv_gnrl_pipe_lrs #(.DW(32), .DEPTH(2), .CUT_READY(0)) u0 (
      .clk(clk), .rst_n(rst_n), .rst_v(rst_v), .flush(flush[0]),
      .i_vld(i_vld[0]), .i_rdy(i_rdy_w[0]), .i_dat(i_dat[0]),
      .o_vld(o_vld_w[0]), .o_rdy(o_rdy[0]), .o_dat(o_dat_w[0]), .occ(occ0));
   sirv_gnrl_pipe_lrs #(.DW(32), .DEPTH(2), .CUT_READY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .rst_v(rst_v), .flush(flush[1]),
      .i_vld(i_vld[1]), .i_rdy(i_rdy_w[1]), .i_dat(i_dat[1]),
      .o_vld(o_vld_w[1]), .o_rdy(o_rdy[1]), .o_dat(o_dat_w[1]), .occ(occ1));
   sirv_gnrl_pipe_lrs #(.DW(32), .DEPTH(1), .CUT_READY(0)) u2 (
      .clk(clk), .rst_n(rst_n), .rst_v(rst_v), .flush(flush[2]),
      .i_vld(i_vld[2]), .i_rdy(i_rdy_w[2]), .i_dat(i_dat[2]),
      .o_vld(o_vld_w[2]), .o_rdy(o_rdy[2]), .o_dat(o_dat_w[2]), .occ(occ2));

   assign occ_v[0] = 32'(occ0);
   assign occ_v[1] = 32'(occ1);
   assign occ_v[2] = 32'(occ2);

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s u%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // Compare every instance against the model and decide which handshakes fire.
   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         int   sz;
         logic ev, rk, known;
         sz    = mq[k].size();
         ev    = (sz > 0) && (ma[k][0] >= DEP[k]);
         known = 1'b1;
         rk    = 1'b0;
         chk("occ", k, occ_v[k], 32'(sz));
         chk("o_vld", k, 32'(o_vld_w[k]), 32'(ev));
         if (ev) chk("o_dat", k, o_dat_w[k], mq[k][0]);
         if (!rst_n) chk("o_dat_rst", k, o_dat_w[k], rst_v);
         if (!rst_n || flush[k]) rk = 1'b0;
         else if (CRV[k] == 0) rk = (sz < DEP[k]) || o_rdy[k];
         else if (sz == MAXO[k]) rk = 1'b0;
         else if (sz <= 1) rk = 1'b1;
         else known = 1'b0;
         if (known) begin
            chk("i_rdy", k, 32'(i_rdy_w[k]), 32'(rk));
            fin[k] = rst_n & i_vld[k] & rk;
         end else begin
            fin[k] = rst_n & i_vld[k] & i_rdy_w[k];
         end
         fout[k] = rst_n & ev & o_rdy[k];
         fdat[k] = i_dat[k];
      end
   endtask

   task automatic update();
      for (int k = 0; k < 3; k++) begin
         if (!rst_n || flush[k]) begin
            mq[k].delete();
            ma[k].delete();
         end else begin
            if (fout[k]) begin
               void'(mq[k].pop_front());
               void'(ma[k].pop_front());
               pops[k]++;
            end
            for (int j = 0; j < ma[k].size(); j++) ma[k][j] = ma[k][j] + 1;
            if (fin[k]) begin
               mq[k].push_back(fdat[k]);
               ma[k].push_back(1);
            end
         end
      end
   endtask

   task automatic cycle();
      #1;
      check_all();
      @(posedge clk);
      update();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic r, input logic [31:0] base);
      for (int k = 0; k < 3; k++) begin
         i_vld[k] = v;
         o_rdy[k] = r;
         flush[k] = 1'b0;
         i_dat[k] = base + 32'(nxt[k]);
      end
      cycle();
      for (int k = 0; k < 3; k++) if (fin[k]) nxt[k]++;
   endtask

   task automatic restart_counts();
      for (int k = 0; k < 3; k++) begin
         nxt[k]  = 1;
         pops[k] = 0;
      end
   endtask

   initial begin
      int acc;
      rst_n = 1'b1;
      rst_v = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         flush[k] = 1'b0; i_vld[k] = 1'b0; o_rdy[k] = 1'b0; i_dat[k] = '0;
         fin[k] = 1'b0; fout[k] = 1'b0; fdat[k] = '0;
      end
      restart_counts();

      // Reset: state visible before any clock edge, held through edges.
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_o_dat", k, o_dat_w[k], 32'hDEAD_BEEF);
         chk("rst_o_vld", k, 32'(o_vld_w[k]), 32'd0);
         chk("rst_occ", k, occ_v[k], 32'd0);
         chk("rst_i_rdy", k, 32'(i_rdy_w[k]), 32'd0);
      end
      @(negedge clk);
      cycle();
      cycle();
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) chk("post_rst_i_rdy", k, 32'(i_rdy_w[k]), 32'd1);
      @(negedge clk);
      cycle();

      // Back-to-back stream 1..8 with downstream always ready.
      restart_counts();
      for (int t = 0; t < 8; t++) drive(1'b1, 1'b1, 32'd0);
      chk("stream_occ", 0, occ_v[0], 32'd2);
      for (int t = 0; t < 4; t++) drive(1'b0, 1'b1, 32'd0);
      for (int k = 0; k < 3; k++) chk("stream_pops", k, 32'(pops[k]), 32'd8);

      // Stalled downstream: skid pipe takes 4 of 5, then drains in order.
      restart_counts();
      acc = 0;
      for (int t = 0; t < 5; t++) begin
         drive(1'b1, 1'b0, 32'd0);
         if (fin[1]) acc++;
      end
      chk("skid_acc", 1, 32'(acc), 32'd4);
      chk("skid_occ", 1, occ_v[1], 32'd4);
      #1 chk("skid_i_rdy", 1, 32'(i_rdy_w[1]), 32'd0);
      @(negedge clk);
      for (int t = 0; t < 20 && nxt[1] <= 5; t++) drive(1'b1, 1'b1, 32'd0);
      chk("skid_push5", 1, 32'(nxt[1]), 32'd6);
      for (int t = 0; t < 6; t++) drive(1'b0, 1'b1, 32'd0);
      chk("skid_pops", 1, 32'(pops[1]), 32'd5);

      // Flush with three items held and an input offered in the same cycle.
      restart_counts();
      for (int t = 0; t < 10 && mq[1].size() < 3; t++) drive(1'b1, 1'b0, 32'hA0);
      chk("fill3", 1, occ_v[1], 32'd3);
      for (int k = 0; k < 3; k++) begin
         flush[k] = 1'b1; i_vld[k] = 1'b1; i_dat[k] = 32'h5555_0000;
      end
      cycle();
      for (int k = 0; k < 3; k++) chk("flush_no_acc", k, 32'(fin[k]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         flush[k] = 1'b0; i_vld[k] = 1'b0;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("flush_occ", k, occ_v[k], 32'd0);
         chk("flush_o_vld", k, 32'(o_vld_w[k]), 32'd0);
         chk("flush_hold", k, o_dat_w[k], 32'hA1);
      end
      @(negedge clk);

      // Asynchronous reset in the middle of traffic.
      restart_counts();
      for (int t = 0; t < 3; t++) drive(1'b1, 1'b0, 32'hB0);
      rst_v = 32'h1234_5678;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("async_o_vld", k, 32'(o_vld_w[k]), 32'd0);
         chk("async_occ", k, occ_v[k], 32'd0);
         chk("async_o_dat", k, o_dat_w[k], 32'h1234_5678);
         chk("async_i_rdy", k, 32'(i_rdy_w[k]), 32'd0);
         mq[k].delete();
         ma[k].delete();
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) i_vld[k] = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();

      // Single-stage pipe kept full while pushing and popping every cycle.
      restart_counts();
      drive(1'b1, 1'b0, 32'hC0);
      for (int t = 0; t < 4; t++) begin
         drive(1'b1, 1'b1, 32'hC0);
         chk("d1_in", 2, 32'(fin[2]), 32'd1);
         chk("d1_out", 2, 32'(fout[2]), 32'd1);
         chk("d1_occ", 2, occ_v[2], 32'd1);
      end
      for (int t = 0; t < 4; t++) drive(1'b0, 1'b1, 32'd0);
      chk("d1_pops", 2, 32'(pops[2]), 32'd5);

      // Randomized traffic with occasional flushes.
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < 3; k++) begin
            i_vld[k] = 1'($urandom_range(0, 1));
            o_rdy[k] = ($urandom_range(0, 3) != 0);
            flush[k] = ($urandom_range(0, 15) == 0);
            i_dat[k] = $urandom();
         end
         cycle();
      end
      for (int t = 0; t < 6; t++) drive(1'b0, 1'b1, 32'd0);
      for (int k = 0; k < 3; k++) chk("final_occ", k, occ_v[k], 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
